// File: rtl/control_alarma.sv
// Alarm sequencer: stores alarm time, edits it in set mode, rings/snoozes on match.
// Latency: trigger edge or button pulse to state/output change is one clk.
// Backpressure: none; button and tick pulses are consumed in the cycle they arrive.
module control_alarma #(
   parameter int HORA_MAX   = 12,
   parameter int T_SONAR    = 60,
   parameter int T_POSPONER = 300,
   parameter int CNT_W      = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       habilitada,
   input  logic       btn_ajuste,
   input  logic       btn_hora,
   input  logic       btn_min,
   input  logic       btn_posponer,
   input  logic       btn_apagar,
   input  logic [3:0] uminuto,
   input  logic [3:0] dminuto,
   input  logic [3:0] horas,
   output logic [3:0] umin,
   output logic [3:0] dmin,
   output logic [3:0] hora,
   output logic       alarm,
   output logic       zumbador,
   output logic       modo_ajuste,
   output logic       pospuesto
);

   typedef enum logic [1:0] {IDLE, AJUSTE, SONANDO, POSPUESTO} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   counter, counter_nxt;
   logic               beep, beep_nxt;
   logic               match_prev;
   logic [3:0]         hora_nxt, dmin_nxt, umin_nxt;
   logic               match, disparo;

   // Rising edge of the time match, qualified by the enable switch.
   assign match   = (umin == uminuto) && (dmin == dminuto) && (hora == horas);
   assign disparo = match && !match_prev && habilitada;

   // State and data registers; match_prev tracks match in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         counter    <= '0;
         beep       <= 1'b1;
         match_prev <= 1'b0;
         hora       <= 4'(HORA_MAX);
         dmin       <= 4'd0;
         umin       <= 4'd0;
      end else begin
         state      <= state_nxt;
         counter    <= counter_nxt;
         beep       <= beep_nxt;
         match_prev <= match;
         hora       <= hora_nxt;
         dmin       <= dmin_nxt;
         umin       <= umin_nxt;
      end
   end

   // Next-state, counter, beep and alarm-time edit logic.
   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      beep_nxt    = beep;
      hora_nxt    = hora;
      dmin_nxt    = dmin;
      umin_nxt    = umin;
      case (state)
         IDLE: begin
            if (btn_ajuste) begin
               state_nxt = AJUSTE;
            end else if (disparo) begin
               state_nxt   = SONANDO;
               counter_nxt = '0;
               beep_nxt    = 1'b1;
            end
         end
         AJUSTE: begin
            if (btn_hora) begin
               hora_nxt = (hora == 4'(HORA_MAX)) ? 4'd1 : hora + 4'd1;
            end
            if (btn_min) begin
               if (umin == 4'd9) begin
                  umin_nxt = 4'd0;
                  dmin_nxt = (dmin == 4'd5) ? 4'd0 : dmin + 4'd1;
               end else begin
                  umin_nxt = umin + 4'd1;
               end
            end
            if (btn_ajuste) begin
               state_nxt = IDLE;
            end
         end
         SONANDO: begin
            if (btn_apagar || !habilitada) begin
               state_nxt = IDLE;
            end else if (btn_posponer) begin
               state_nxt   = POSPUESTO;
               counter_nxt = '0;
            end else if (tick_1hz) begin
               if (counter == CNT_W'(T_SONAR - 1)) begin
                  state_nxt = IDLE;
               end else begin
                  counter_nxt = counter + 1'b1;
                  beep_nxt    = !beep;
               end
            end
         end
         POSPUESTO: begin
            if (btn_apagar || !habilitada) begin
               state_nxt = IDLE;
            end else if (tick_1hz) begin
               if (counter == CNT_W'(T_POSPONER - 1)) begin
                  state_nxt   = SONANDO;
                  counter_nxt = '0;
                  beep_nxt    = 1'b1;
               end else begin
                  counter_nxt = counter + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from registered state only.
   assign alarm       = (state == SONANDO);
   assign zumbador    = alarm && beep;
   assign modo_ajuste = (state == AJUSTE);
   assign pospuesto   = (state == POSPUESTO);

endmodule

// File: tb/tb_control_alarma.sv
// Directed bench for control_alarma with short ringing/snooze timeouts.
// Observed vector = {hora, dmin, umin, alarm, zumbador, modo_ajuste, pospuesto}.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_control_alarma;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       habilitada = 1'b0;
   logic       btn_ajuste = 1'b0;
   logic       btn_hora = 1'b0;
   logic       btn_min = 1'b0;
   logic       btn_posponer = 1'b0;
   logic       btn_apagar = 1'b0;
   logic [3:0] uminuto = 4'd0;
   logic [3:0] dminuto = 4'd0;
   logic [3:0] horas = 4'd3;
   logic [3:0] umin, dmin, hora;
   logic       alarm, zumbador, modo_ajuste, pospuesto;

   int         checks = 0;
   int         failures = 0;
   logic [15:0] obs, expv;

   control_alarma #(.HORA_MAX(12), .T_SONAR(4), .T_POSPONER(3), .CNT_W(9)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .habilitada(habilitada),
      .btn_ajuste(btn_ajuste), .btn_hora(btn_hora), .btn_min(btn_min),
      .btn_posponer(btn_posponer), .btn_apagar(btn_apagar),
      .uminuto(uminuto), .dminuto(dminuto), .horas(horas),
      .umin(umin), .dmin(dmin), .hora(hora), .alarm(alarm), .zumbador(zumbador),
      .modo_ajuste(modo_ajuste), .pospuesto(pospuesto)
   );

   always #5 clk = ~clk;

   assign obs = {hora, dmin, umin, alarm, zumbador, modo_ajuste, pospuesto};

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic aj, input logic hr, input logic mn,
                        input logic pp, input logic ap, input logic tk);
      btn_ajuste = aj; btn_hora = hr; btn_min = mn;
      btn_posponer = pp; btn_apagar = ap; tick_1hz = tk;
      step(1);
      btn_ajuste = 0; btn_hora = 0; btn_min = 0;
      btn_posponer = 0; btn_apagar = 0; tick_1hz = 0;
   endtask

   task automatic set_clock(input logic [3:0] h, input logic [3:0] d, input logic [3:0] u);
      horas = h; dminuto = d; uminuto = u;
   endtask

   // Clock leaves 7:05 and returns, giving a fresh match edge.
   task automatic retrigger;
      set_clock(4'd7, 4'd0, 4'd6);
      step(1);
      set_clock(4'd7, 4'd0, 4'd5);
      step(1);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
      expv = {4'd12, 4'd0, 4'd0, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL reset obs=%h exp=%h", obs, expv); end
   endtask

   task automatic test_ajuste;
      press(1, 0, 0, 0, 0, 0);
      expv = {4'd12, 4'd0, 4'd0, 4'b0010};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL enter_ajuste obs=%h exp=%h", obs, expv); end
      repeat (7) press(0, 1, 0, 0, 0, 0);
      repeat (5) press(0, 0, 1, 0, 0, 0);
      press(1, 0, 0, 0, 0, 0);
      expv = {4'd7, 4'd0, 4'd5, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL set_705 obs=%h exp=%h", obs, expv); end
      press(1, 0, 0, 0, 0, 0);
      repeat (4) press(0, 0, 1, 0, 0, 0);
      expv = {4'd7, 4'd0, 4'd9, 4'b0010};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL min_09 obs=%h exp=%h", obs, expv); end
      press(0, 0, 1, 0, 0, 0);
      expv = {4'd7, 4'd1, 4'd0, 4'b0010};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL min_carry obs=%h exp=%h", obs, expv); end
      repeat (50) press(0, 0, 1, 0, 0, 0);
      expv = {4'd7, 4'd0, 4'd0, 4'b0010};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL min_wrap obs=%h exp=%h", obs, expv); end
      repeat (6) press(0, 1, 0, 0, 0, 0);
      expv = {4'd1, 4'd0, 4'd0, 4'b0010};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL hora_wrap obs=%h exp=%h", obs, expv); end
      press(0, 1, 1, 0, 0, 0);
      expv = {4'd2, 4'd0, 4'd1, 4'b0010};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL hora_min_both obs=%h exp=%h", obs, expv); end
      repeat (5) press(0, 1, 0, 0, 0, 0);
      repeat (4) press(0, 0, 1, 0, 0, 0);
      press(1, 0, 0, 0, 0, 0);
      press(0, 1, 1, 0, 0, 0);
      expv = {4'd7, 4'd0, 4'd5, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL edit_outside_ajuste obs=%h exp=%h", obs, expv); end
   endtask

   task automatic test_ringing;
      habilitada = 1'b1;
      step(1);
      set_clock(4'd7, 4'd0, 4'd5);
      #1;
      checks++;
      if (alarm !== 1'b0) begin failures++; $display("FAIL no_comb_path alarm=%b exp=0", alarm); end
      step(1);
      expv = {4'd7, 4'd0, 4'd5, 4'b1100};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL ring_start obs=%h exp=%h", obs, expv); end
      press(0, 0, 0, 0, 0, 1);
      expv = {4'd7, 4'd0, 4'd5, 4'b1000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL ring_tick1 obs=%h exp=%h", obs, expv); end
      step(2);
      press(0, 0, 0, 0, 0, 1);
      expv = {4'd7, 4'd0, 4'd5, 4'b1100};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL ring_tick2 obs=%h exp=%h", obs, expv); end
      press(0, 0, 0, 0, 0, 1);
      expv = {4'd7, 4'd0, 4'd5, 4'b1000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL ring_tick3 obs=%h exp=%h", obs, expv); end
      press(0, 0, 0, 0, 0, 1);
      expv = {4'd7, 4'd0, 4'd5, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL ring_timeout obs=%h exp=%h", obs, expv); end
      step(5);
      checks++;
      if (alarm !== 1'b0) begin failures++; $display("FAIL no_retrigger alarm=%b exp=0", alarm); end
   endtask

   task automatic test_snooze;
      retrigger();
      press(0, 0, 0, 1, 0, 0);
      expv = {4'd7, 4'd0, 4'd5, 4'b0001};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL snooze_enter obs=%h exp=%h", obs, expv); end
      press(0, 0, 0, 0, 0, 1);
      press(0, 0, 0, 0, 0, 1);
      expv = {4'd7, 4'd0, 4'd5, 4'b0001};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL snooze_hold obs=%h exp=%h", obs, expv); end
      press(0, 0, 0, 0, 0, 1);
      expv = {4'd7, 4'd0, 4'd5, 4'b1100};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL snooze_expire obs=%h exp=%h", obs, expv); end
      press(0, 0, 0, 0, 1, 0);
      expv = {4'd7, 4'd0, 4'd5, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL apagar obs=%h exp=%h", obs, expv); end
   endtask

   task automatic test_priority;
      retrigger();
      press(0, 0, 0, 1, 1, 0);
      expv = {4'd7, 4'd0, 4'd5, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL apagar_over_posponer obs=%h exp=%h", obs, expv); end
      retrigger();
      checks++;
      if (alarm !== 1'b1) begin failures++; $display("FAIL ring_again alarm=%b exp=1", alarm); end
      habilitada = 1'b0;
      step(1);
      checks++;
      if (alarm !== 1'b0) begin failures++; $display("FAIL disable_stops alarm=%b exp=0", alarm); end
      retrigger();
      checks++;
      if (alarm !== 1'b0) begin failures++; $display("FAIL disabled_no_trigger alarm=%b exp=0", alarm); end
      habilitada = 1'b1;
      step(2);
      checks++;
      if (alarm !== 1'b0) begin failures++; $display("FAIL enable_on_held_match alarm=%b exp=0", alarm); end
   endtask

   task automatic test_reset_sonando;
      retrigger();
      checks++;
      if (alarm !== 1'b1) begin failures++; $display("FAIL ring_before_reset alarm=%b exp=1", alarm); end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      expv = {4'd12, 4'd0, 4'd0, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL reset_in_sonando obs=%h exp=%h", obs, expv); end
      press(1, 0, 0, 0, 0, 0);
      set_clock(4'd12, 4'd0, 4'd0);
      step(2);
      press(1, 0, 0, 0, 0, 0);
      step(3);
      expv = {4'd12, 4'd0, 4'd0, 4'b0000};
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL exit_ajuste_on_match obs=%h exp=%h", obs, expv); end
   endtask

   initial begin
      test_reset();
      test_ajuste();
      test_ringing();
      test_snooze();
      test_priority();
      test_reset_sonando();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
